// File: rtl/flit_to_axis_ejector.sv
// flit_to_axis_ejector: buffers credit-based flits and reassembles them into AXI-Stream beats
module flit_to_axis_ejector #(
  parameter int TDATA_WIDTH          = 128,
  parameter int SERIALIZATION_FACTOR = 1,
  parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
  parameter int TID_WIDTH            = 2,
  parameter int TDEST_WIDTH          = 4,
  parameter int DEST_WIDTH           = TDEST_WIDTH + TID_WIDTH,
  parameter int BUFFER_DEPTH         = 8
) (
  input  logic                   clk_noc,
  input  logic                   rst_noc_sync,
  input  logic [FLIT_WIDTH-1:0]  data_in,
  input  logic [DEST_WIDTH-1:0]  dest_in,
  input  logic                   is_tail_in,
  input  logic                   send_in,
  output logic                   credit_out,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TID_WIDTH-1:0]   axis_out_tid,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest,
  output logic                   overflow_err,
  output logic                   framing_err
);
  localparam int AW = BUFFER_DEPTH > 1 ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam int KW = SERIALIZATION_FACTOR > 1 ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam int EW = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam logic [KW-1:0] K_LAST = KW'(SERIALIZATION_FACTOR - 1);
  localparam logic [AW-1:0] P_LAST = AW'(BUFFER_DEPTH - 1);
  localparam logic [CW-1:0] C_FULL = CW'(BUFFER_DEPTH);

  logic [EW-1:0]          mem [BUFFER_DEPTH];
  logic [AW-1:0]          wptr, rptr;
  logic [CW-1:0]          cnt;
  logic [KW-1:0]          k;
  logic [TDATA_WIDTH-1:0] acc, beat;
  logic [DEST_WIDTH-1:0]  dest0, h_dest, b_dest;
  logic [FLIT_WIDTH-1:0]  h_data;
  logic                   h_tail, empty, full, completing, pop, push;

  assign {h_tail, h_dest, h_data} = mem[rptr];

  always_comb begin
    empty      = cnt == '0;
    full       = cnt == C_FULL;
    completing = h_tail || k == K_LAST;
    pop        = !empty && (!completing || !axis_out_tvalid || axis_out_tready);
    push       = send_in && (!full || pop);
    b_dest     = k == '0 ? h_dest : dest0;
    // acc slots at and above k are always zero, so OR-ing in the head flit zero-fills an early tail
    beat       = acc | (TDATA_WIDTH'(h_data) << (int'(k) * FLIT_WIDTH));
  end

  always_ff @(posedge clk_noc)
    if (push) mem[wptr] <= {is_tail_in, dest_in, data_in};

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      wptr            <= '0;
      rptr            <= '0;
      cnt             <= '0;
      k               <= '0;
      acc             <= '0;
      dest0           <= '0;
      credit_out      <= 1'b0;
      axis_out_tvalid <= 1'b0;
      axis_out_tdata  <= '0;
      axis_out_tlast  <= 1'b0;
      axis_out_tid    <= '0;
      axis_out_tdest  <= '0;
      overflow_err    <= 1'b0;
      framing_err     <= 1'b0;
    end else begin
      credit_out <= pop;
      cnt        <= cnt + CW'(push) - CW'(pop);
      if (push) wptr <= wptr == P_LAST ? '0 : wptr + 1'b1;
      if (pop) rptr <= rptr == P_LAST ? '0 : rptr + 1'b1;
      if (send_in && !push) overflow_err <= 1'b1;
      if (pop && completing) begin
        axis_out_tvalid <= 1'b1;
        axis_out_tdata  <= beat;
        axis_out_tlast  <= h_tail;
        axis_out_tid    <= b_dest[DEST_WIDTH-1 -: TID_WIDTH];
        axis_out_tdest  <= b_dest[TDEST_WIDTH-1:0];
        k               <= '0;
        acc             <= '0;
        if (h_tail && k != K_LAST) framing_err <= 1'b1;
      end else if (axis_out_tready) begin
        axis_out_tvalid <= 1'b0;
      end
      if (pop && !completing) begin
        acc[int'(k) * FLIT_WIDTH +: FLIT_WIDTH] <= h_data;
        if (k == '0) dest0 <= h_dest;
        k <= k + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_flit_to_axis_ejector.sv
// tb_flit_to_axis_ejector: directed bench for a 1-flit/beat and a 4-flit/beat ejector against a reassembly model
module tb_flit_to_axis_ejector;
  typedef struct packed {
    logic [127:0] d;
    logic         l;
    logic [1:0]   id;
    logic [3:0]   ds;
  } beat_t;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] a_data = '0, a_tdata;
  logic [5:0]   a_dest = '0;
  logic         a_tail = 1'b0, a_send = 1'b0, a_drop = 1'b0, a_tready = 1'b1;
  logic         a_credit, a_tvalid, a_tlast, a_ovf, a_frm;
  logic [1:0]   a_tid;
  logic [3:0]   a_tdest;

  logic [31:0]  b_data = '0;
  logic [127:0] b_tdata;
  logic [5:0]   b_dest = '0;
  logic         b_tail = 1'b0, b_send = 1'b0, b_tready = 1'b1;
  logic         b_credit, b_tvalid, b_tlast, b_ovf, b_frm;
  logic [1:0]   b_tid;
  logic [3:0]   b_tdest;

  flit_to_axis_ejector #(.TDATA_WIDTH(128), .SERIALIZATION_FACTOR(1)) dut_a (
    .clk_noc(clk), .rst_noc_sync(rst), .data_in(a_data), .dest_in(a_dest), .is_tail_in(a_tail),
    .send_in(a_send), .credit_out(a_credit), .axis_out_tvalid(a_tvalid), .axis_out_tready(a_tready),
    .axis_out_tdata(a_tdata), .axis_out_tlast(a_tlast), .axis_out_tid(a_tid), .axis_out_tdest(a_tdest),
    .overflow_err(a_ovf), .framing_err(a_frm));

  flit_to_axis_ejector #(.TDATA_WIDTH(128), .SERIALIZATION_FACTOR(4)) dut_b (
    .clk_noc(clk), .rst_noc_sync(rst), .data_in(b_data), .dest_in(b_dest), .is_tail_in(b_tail),
    .send_in(b_send), .credit_out(b_credit), .axis_out_tvalid(b_tvalid), .axis_out_tready(b_tready),
    .axis_out_tdata(b_tdata), .axis_out_tlast(b_tlast), .axis_out_tid(b_tid), .axis_out_tdest(b_tdest),
    .overflow_err(b_ovf), .framing_err(b_frm));

  int n_cmp = 0, n_fail = 0;
  int mk[2], ccnt[2];
  logic [127:0] macc[2];
  logic [5:0]   mdst[2];
  logic         stall[2];
  beat_t        held[2];
  beat_t        qa[$], qb[$];

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  // Reassembly as seen from the sender: flit j of a packet lands in slot j, beat closes on tail or full
  function automatic void mflit(input int i, input logic [127:0] d, input logic [5:0] dst, input logic tl);
    int sf, fw;
    logic [127:0] m;
    beat_t e;
    sf = (i == 0) ? 1 : 4;
    fw = 128 / sf;
    m  = (sf == 1) ? '1 : ((128'd1 << fw) - 128'd1);
    if (mk[i] == 0) mdst[i] = dst;
    macc[i] = macc[i] | ((d & m) << (mk[i] * fw));
    if (tl || mk[i] == sf - 1) begin
      e = '{macc[i], tl, mdst[i][5:4], mdst[i][3:0]};
      if (i == 0) qa.push_back(e); else qb.push_back(e);
      macc[i] = '0;
      mk[i]   = 0;
    end else mk[i]++;
  endfunction

  task automatic mon(input int i, input logic s, input logic dr, input logic [127:0] d, input logic [5:0] dst,
                     input logic tl, input logic v, input logic r, input beat_t act, input logic cr);
    beat_t e;
    if (rst) begin
      mk[i] = 0; macc[i] = '0; stall[i] = 1'b0;
      if (i == 0) qa.delete(); else qb.delete();
      return;
    end
    if (s && !dr) mflit(i, d, dst, tl);
    if (stall[i]) chk(i == 0 ? "a_hold" : "b_hold", {v, act}, {1'b1, held[i]});
    if (v && r) begin
      if ((i == 0 ? qa.size() : qb.size()) == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL %s: actual beat %h required no beat", i == 0 ? "a_beat" : "b_beat", act);
      end else begin
        e = (i == 0) ? qa.pop_front() : qb.pop_front();
        chk(i == 0 ? "a_beat" : "b_beat", act, e);
      end
    end
    stall[i] = v && !r;
    held[i]  = act;
    if (cr) ccnt[i]++;
  endtask

  task automatic step();
    @(negedge clk);
    mon(0, a_send, a_drop, a_data, a_dest, a_tail, a_tvalid, a_tready, {a_tdata, a_tlast, a_tid, a_tdest}, a_credit);
    mon(1, b_send, 1'b0, 128'(b_data), b_dest, b_tail, b_tvalid, b_tready, {b_tdata, b_tlast, b_tid, b_tdest}, b_credit);
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [127:0] d, input logic [5:0] ds, input logic t, input logic dr);
    a_send = 1'b1; a_data = d; a_dest = ds; a_tail = t; a_drop = dr;
    step();
    a_send = 1'b0; a_tail = 1'b0; a_drop = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d, input logic [5:0] ds, input logic t);
    b_send = 1'b1; b_data = d; b_dest = ds; b_tail = t;
    step();
    b_send = 1'b0; b_tail = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    while (!b_tvalid && n < 12) begin
      step();
      n++;
    end
    if (!b_tvalid) begin
      n_cmp++; n_fail++;
      $display("FAIL b_tvalid_wait: actual 0 after %0d cycles required 1", n);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("a_reset", {a_tvalid, a_credit, a_tdata, a_tlast, a_tid, a_tdest, a_ovf, a_frm}, '0);
    chk("b_reset", {b_tvalid, b_credit, b_tdata, b_tlast, b_tid, b_tdest, b_ovf, b_frm}, '0);
  endtask

  initial begin
    int base;
    logic [31:0] p[4];
    for (int i = 0; i < 2; i++) begin
      mk[i] = 0; ccnt[i] = 0; macc[i] = '0; mdst[i] = '0; stall[i] = 1'b0; held[i] = '0;
    end
    repeat (3) step();
    chk_reset_outputs();
    rst = 1'b0;
    step();

    // single flit, SF=1
    send_a({16{8'hA5}}, 6'b10_0011, 1'b1, 1'b0);
    chk("single_c1", {a_tvalid, a_credit}, 2'b00);
    step();
    chk("single_c2", {a_tvalid, a_credit, a_tdata, a_tlast, a_tid, a_tdest},
        {1'b1, 1'b1, {16{8'hA5}}, 1'b1, 2'd2, 4'd3});
    step();
    chk("single_c3_credit", a_credit, 1'b0);

    // four-flit reassembly, SF=4
    base = ccnt[1];
    p = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    for (int j = 0; j < 4; j++) send_b(p[j], 6'b01_0101, j == 3);
    wait_b();
    chk("reasm_beat", {b_tdata, b_tlast, b_tid, b_tdest},
        {128'h44444444_33333333_22222222_11111111, 1'b1, 2'd1, 4'd5});
    repeat (3) step();
    chk("reasm_credits", ccnt[1] - base, 4);
    chk("reasm_no_frm", b_frm, 1'b0);

    // backpressure: nine flits into a stalled SF=1 port
    a_tready = 1'b0;
    base = ccnt[0];
    for (int j = 0; j < 9; j++) send_a({4{32'(j + 1)}}, 6'(j), j[0], 1'b0);
    repeat (2) step();
    chk("bp_credits", ccnt[0] - base, 1);
    chk("bp_held", {a_tvalid, a_tdata, a_tlast, a_tid, a_tdest}, {1'b1, {4{32'h1}}, 1'b0, 2'd0, 4'd0});
    chk("bp_no_ovf", a_ovf, 1'b0);

    // overflow: tenth flit while full and stalled is dropped
    send_a(128'hDEAD, 6'b11_1111, 1'b1, 1'b1);
    chk("ovf_set", a_ovf, 1'b1);
    a_tready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      chk("drain_valid", a_tvalid, 1'b1);
      step();
    end
    chk("drain_done", a_tvalid, 1'b0);
    repeat (2) step();
    chk("drain_credits", ccnt[0] - base, 9);
    chk("ovf_sticky", a_ovf, 1'b1);

    // early tail, then a full beat without tail starting at slot 0
    base = ccnt[1];
    send_b(32'hAAAAAAAA, 6'b11_0010, 1'b0);
    send_b(32'hBBBBBBBB, 6'b11_0010, 1'b1);
    wait_b();
    chk("early_beat", {b_tdata, b_tlast, b_tid, b_tdest},
        {128'h00000000_00000000_BBBBBBBB_AAAAAAAA, 1'b1, 2'd3, 4'd2});
    chk("early_frm", b_frm, 1'b1);
    step();
    p = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
    for (int j = 0; j < 4; j++) send_b(p[j], 6'b00_0111, 1'b0);
    wait_b();
    chk("notail_beat", {b_tdata, b_tlast, b_tid, b_tdest},
        {128'h04040404_03030303_02020202_01010101, 1'b0, 2'd0, 4'd7});
    repeat (3) step();
    chk("early_credits", ccnt[1] - base, 6);

    // reset in the middle of a beat
    send_b(32'hCCCCCCCC, 6'b01_0001, 1'b0);
    send_b(32'hDDDDDDDD, 6'b01_0001, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs();
    base = ccnt[1];
    repeat (3) step();
    chk("rst_no_credits", ccnt[1] - base, 0);
    chk("rst_no_valid", b_tvalid, 1'b0);
    p = '{32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    for (int j = 0; j < 4; j++) send_b(p[j], 6'b10_1001, j == 3);
    wait_b();
    chk("fresh_beat", {b_tdata, b_tlast, b_tid, b_tdest},
        {128'h88888888_77777777_66666666_55555555, 1'b1, 2'd2, 4'd9});
    repeat (3) step();
    chk("fresh_credits", ccnt[1] - base, 4);
    chk("model_drained", {32'(qa.size()), 32'(qb.size())}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
